// File: rtl/cycloneiiils_obuf_share_ctrl.sv
// Arbitrates one tri-state output buffer between NREQ core requesters: round-robin grant,
// bounded hold, oe-low turnaround, power-up devoe delay and idle-only termination updates.
module cycloneiiils_obuf_share_ctrl #(
    parameter int unsigned NREQ        = 4,
    parameter int unsigned TURNAROUND  = 2,
    parameter int unsigned MAX_HOLD    = 16,
    parameter int unsigned DEVOE_DELAY = 8,
    parameter logic [15:0] RTERM_CODE  = 16'h0
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [NREQ-1:0] req,
    input  logic [NREQ-1:0] req_data,
    input  logic            stc_load,
    input  logic [15:0]     stc_code,
    output logic [NREQ-1:0] gnt,
    output logic            obuf_i,
    output logic            obuf_oe,
    output logic            obuf_devoe,
    output logic [15:0]     obuf_stc,
    output logic            stc_pending
);

    localparam int unsigned IW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int unsigned CW = 8;
    localparam int unsigned TW = 4;
    localparam int unsigned SW = 16;

    typedef enum logic [1:0] {
        ST_INIT,
        ST_IDLE,
        ST_DRIVE,
        ST_TURN
    } state_t;

    state_t          state, state_d;
    logic [IW-1:0]   owner, owner_d;
    logic [IW-1:0]   rr, rr_d;
    logic [CW-1:0]   init_cnt, init_cnt_d;
    logic [CW-1:0]   hold_cnt, hold_cnt_d;
    logic [TW-1:0]   turn_cnt, turn_cnt_d;
    logic [SW-1:0]   stc_hold, stc_hold_d;
    logic [SW-1:0]   obuf_stc_d;
    logic            stc_pending_d;
    logic [NREQ-1:0] gnt_d;
    logic            obuf_i_d;
    logic            obuf_oe_d;
    logic            obuf_devoe_d;
    logic            stc_apply;

    logic            pick_found;
    logic [IW-1:0]   pick_idx;
    logic [IW-1:0]   cand;
    logic            others_req;

    // First requester at or after the round-robin pointer, wrapping at NREQ.
    always_comb begin
        pick_found = 1'b0;
        pick_idx   = '0;
        cand       = '0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            cand = IW'((32'(rr) + k) % NREQ);
            if (!pick_found && req[cand]) begin
                pick_found = 1'b1;
                pick_idx   = cand;
            end
        end
    end

    assign others_req = |(req & ~gnt);

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= ST_INIT;
            owner       <= '0;
            rr          <= '0;
            init_cnt    <= '0;
            hold_cnt    <= '0;
            turn_cnt    <= '0;
            stc_hold    <= RTERM_CODE;
            obuf_stc    <= RTERM_CODE;
            stc_pending <= 1'b0;
            gnt         <= '0;
            obuf_i      <= 1'b0;
            obuf_oe     <= 1'b0;
            obuf_devoe  <= 1'b0;
        end else begin
            state       <= state_d;
            owner       <= owner_d;
            rr          <= rr_d;
            init_cnt    <= init_cnt_d;
            hold_cnt    <= hold_cnt_d;
            turn_cnt    <= turn_cnt_d;
            stc_hold    <= stc_hold_d;
            obuf_stc    <= obuf_stc_d;
            stc_pending <= stc_pending_d;
            gnt         <= gnt_d;
            obuf_i      <= obuf_i_d;
            obuf_oe     <= obuf_oe_d;
            obuf_devoe  <= obuf_devoe_d;
        end
    end

    always_comb begin
        state_d       = state;
        owner_d       = owner;
        rr_d          = rr;
        init_cnt_d    = init_cnt;
        hold_cnt_d    = hold_cnt;
        turn_cnt_d    = turn_cnt;
        stc_hold_d    = stc_hold;
        obuf_stc_d    = obuf_stc;
        stc_pending_d = stc_pending;
        gnt_d         = gnt;
        obuf_i_d      = obuf_i;
        obuf_oe_d     = obuf_oe;
        obuf_devoe_d  = obuf_devoe;
        stc_apply     = 1'b0;

        case (state)
            ST_INIT: begin
                if (init_cnt == CW'(DEVOE_DELAY)) begin
                    obuf_devoe_d = 1'b1;
                    state_d      = ST_IDLE;
                end else begin
                    init_cnt_d = init_cnt + CW'(1);
                end
            end
            ST_IDLE: begin
                // A pending code load takes the whole idle cycle; arbitration waits.
                if (stc_pending) begin
                    stc_apply = 1'b1;
                end else if (pick_found) begin
                    state_d         = ST_DRIVE;
                    owner_d         = pick_idx;
                    rr_d            = (pick_idx == IW'(NREQ - 1)) ? '0 : pick_idx + IW'(1);
                    gnt_d           = '0;
                    gnt_d[pick_idx] = 1'b1;
                    obuf_oe_d       = 1'b1;
                    obuf_i_d        = 1'b0;
                    hold_cnt_d      = CW'(1);
                end
            end
            ST_DRIVE: begin
                if (!req[owner] || ((hold_cnt == CW'(MAX_HOLD)) && others_req)) begin
                    state_d    = ST_TURN;
                    turn_cnt_d = '0;
                    gnt_d      = '0;
                    obuf_oe_d  = 1'b0;
                    obuf_i_d   = 1'b0;
                end else begin
                    obuf_i_d = req_data[owner];
                    if (hold_cnt != CW'(MAX_HOLD)) begin
                        hold_cnt_d = hold_cnt + CW'(1);
                    end
                end
            end
            ST_TURN: begin
                if (turn_cnt == TW'(TURNAROUND - 1)) begin
                    state_d = ST_IDLE;
                end else begin
                    turn_cnt_d = turn_cnt + TW'(1);
                end
            end
            default: state_d = ST_INIT;
        endcase

        // A fresh load always wins over the clear from applying the previous code.
        if (stc_apply) begin
            obuf_stc_d    = stc_hold;
            stc_pending_d = 1'b0;
        end
        if (stc_load) begin
            stc_hold_d    = stc_code;
            stc_pending_d = 1'b1;
        end
    end

endmodule

// File: tb/tb_cycloneiiils_obuf_share_ctrl.sv
// Bench for cycloneiiils_obuf_share_ctrl: directed vectors with literal expectations plus
// a cycle-level behavioural model compared against every output on each negedge.
module tb_cycloneiiils_obuf_share_ctrl;

    localparam int unsigned NREQ        = 4;
    localparam int unsigned TURNAROUND  = 2;
    localparam int unsigned MAX_HOLD    = 16;
    localparam int unsigned DEVOE_DELAY = 8;
    localparam logic [15:0] RTERM_CODE  = 16'h0000;

    logic        clk;
    logic        reset;
    logic [3:0]  req;
    logic [3:0]  req_data;
    logic        stc_load;
    logic [15:0] stc_code;
    logic [3:0]  gnt;
    logic        obuf_i;
    logic        obuf_oe;
    logic        obuf_devoe;
    logic [15:0] obuf_stc;
    logic        stc_pending;

    int checks = 0;
    int errors = 0;

    cycloneiiils_obuf_share_ctrl #(
        .NREQ        (NREQ),
        .TURNAROUND  (TURNAROUND),
        .MAX_HOLD    (MAX_HOLD),
        .DEVOE_DELAY (DEVOE_DELAY),
        .RTERM_CODE  (RTERM_CODE)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .req         (req),
        .req_data    (req_data),
        .stc_load    (stc_load),
        .stc_code    (stc_code),
        .gnt         (gnt),
        .obuf_i      (obuf_i),
        .obuf_oe     (obuf_oe),
        .obuf_devoe  (obuf_devoe),
        .obuf_stc    (obuf_stc),
        .stc_pending (stc_pending)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: pad ownership, cycles since reset, oe-low cycles since release, code staging.
    int          m_since;
    int          m_owner;
    int          m_held;
    int          m_quiet;
    int          m_next;
    logic        m_i;
    logic        m_devoe;
    logic        m_pend;
    logic [15:0] m_stc;
    logic [15:0] m_hold;
    bit          m_valid = 1'b0;

    task automatic model_step();
        logic       apply;
        logic [3:0] oth;
        bit         found;
        int         idx;
        apply = 1'b0;
        if (reset) begin
            m_since = 0; m_owner = -1; m_held = 0; m_quiet = 0; m_next = 0;
            m_i = 1'b0; m_devoe = 1'b0; m_pend = 1'b0;
            m_stc = RTERM_CODE; m_hold = RTERM_CODE; m_valid = 1'b1;
            return;
        end
        if (!m_valid) return;
        if (!m_devoe) begin
            m_since++;
            if (m_since > int'(DEVOE_DELAY)) begin
                m_devoe = 1'b1;
                m_quiet = int'(TURNAROUND) + 1;
            end
        end else if (m_owner >= 0) begin
            oth = req & ~(4'(1) << m_owner);
            if (!req[2'(m_owner)] || (m_held >= int'(MAX_HOLD) && oth != 4'b0)) begin
                m_owner = -1;
                m_quiet = 1;
                m_i     = 1'b0;
            end else begin
                m_i = req_data[2'(m_owner)];
                if (m_held < int'(MAX_HOLD)) m_held++;
            end
        end else if (m_quiet <= int'(TURNAROUND)) begin
            m_quiet++;
        end else if (m_pend) begin
            apply = 1'b1;
        end else if (req != 4'b0) begin
            found = 1'b0;
            for (int k = 0; k < int'(NREQ); k++) begin
                idx = (m_next + k) % int'(NREQ);
                if (!found && req[2'(idx)]) begin
                    found   = 1'b1;
                    m_owner = idx;
                end
            end
            m_held = 1;
            m_next = (m_owner + 1) % int'(NREQ);
            m_i    = 1'b0;
        end
        if (apply) begin
            m_stc  = m_hold;
            m_pend = 1'b0;
        end
        if (stc_load) begin
            m_hold = stc_code;
            m_pend = 1'b1;
        end
    endtask

    initial begin
        logic [3:0] exp_gnt;
        forever begin
            @(posedge clk);
            model_step();
            @(negedge clk);
            if (m_valid) begin
                exp_gnt = (m_owner >= 0) ? (4'(1) << m_owner) : 4'b0;
                check("m_gnt",     32'(gnt),         32'(exp_gnt));
                check("m_oe",      32'(obuf_oe),     32'(m_owner >= 0));
                check("m_i",       32'(obuf_i),      32'(m_i));
                check("m_devoe",   32'(obuf_devoe),  32'(m_devoe));
                check("m_stc",     32'(obuf_stc),    32'(m_stc));
                check("m_pending", 32'(stc_pending), 32'(m_pend));
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Counts oe-low samples before the next grant, then the grant's length in cycles.
    task automatic next_grant(output logic [3:0] g, output int gap, output int len);
        gap = 0;
        while (gnt == 4'b0 && gap < 300) begin
            gap++;
            step();
        end
        g   = gnt;
        len = 0;
        while (gnt == g && g != 4'b0 && len < 300) begin
            len++;
            step();
        end
    endtask

    initial begin
        logic [3:0] exp_rot [5];
        logic [3:0] g;
        int         gap;
        int         len;
        int         w;
        logic       d_prev;

        exp_rot = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        reset = 1'b1; req = 4'b0; req_data = 4'b0; stc_load = 1'b0; stc_code = 16'h0;
        step();
        step();
        check("rst_gnt",     32'(gnt),         32'h0);
        check("rst_oe",      32'(obuf_oe),     32'h0);
        check("rst_devoe",   32'(obuf_devoe),  32'h0);
        check("rst_stc",     32'(obuf_stc),    32'h0);
        check("rst_pending", 32'(stc_pending), 32'h0);

        // Power-up: devoe low for 8 cycles, requests ignored.
        reset = 1'b0;
        req   = 4'b1111;
        for (int k = 1; k <= 8; k++) begin
            step();
            check("init_devoe", 32'(obuf_devoe), 32'h0);
            check("init_gnt",   32'(gnt),        32'h0);
        end
        step();
        check("devoe_up", 32'(obuf_devoe), 32'h1);
        check("idle_gnt", 32'(gnt),        32'h0);

        // All requesting: rotate 0,1,2,3,0, 16 cycles each, 3 oe-low cycles between.
        for (int n = 0; n < 5; n++) begin
            next_grant(g, gap, len);
            check("rot_gnt", 32'(g),   32'(exp_rot[n]));
            check("rot_len", 32'(len), 32'd16);
            check("rot_gap", 32'(gap), (n == 0) ? 32'd1 : 32'd3);
        end

        // Lone requester 2 holds 100 cycles with toggling data.
        req = 4'b0100;
        w   = 0;
        while (gnt == 4'b0 && w < 50) begin
            w++;
            step();
        end
        check("lone_gnt",   32'(gnt),    32'h4);
        check("lone_wait",  32'(w),      32'd3);
        check("lone_i0",    32'(obuf_i), 32'h0);
        for (int k = 0; k < 100; k++) begin
            req_data = {1'b0, ~req_data[2], 2'b0};
            d_prev   = req_data[2];
            step();
            check("hold_gnt", 32'(gnt),     32'h4);
            check("hold_oe",  32'(obuf_oe), 32'h1);
            check("hold_i",   32'(obuf_i),  32'(d_prev));
        end

        // Code load while driving is deferred.
        stc_load = 1'b1; stc_code = 16'hA5A5;
        step();
        stc_load = 1'b0; stc_code = 16'h0;
        check("ld_pending", 32'(stc_pending), 32'h1);
        check("ld_stc",     32'(obuf_stc),    32'h0);
        for (int k = 0; k < 3; k++) begin
            step();
            check("drv_stc",     32'(obuf_stc),    32'h0);
            check("drv_pending", 32'(stc_pending), 32'h1);
        end

        // Release to requester 1; 2 TURN + 1 IDLE, then code applied, second load collides.
        req = 4'b0010;
        for (int k = 0; k < 3; k++) begin
            step();
            check("rel_gnt",     32'(gnt),         32'h0);
            check("rel_oe",      32'(obuf_oe),     32'h0);
            check("rel_stc",     32'(obuf_stc),    32'h0);
            check("rel_pending", 32'(stc_pending), 32'h1);
        end
        stc_load = 1'b1; stc_code = 16'h1234;
        step();
        stc_load = 1'b0; stc_code = 16'h0;
        check("apply1_stc",     32'(obuf_stc),    32'hA5A5);
        check("apply1_pending", 32'(stc_pending), 32'h1);
        check("apply1_gnt",     32'(gnt),         32'h0);
        step();
        check("apply2_stc",     32'(obuf_stc),    32'h1234);
        check("apply2_pending", 32'(stc_pending), 32'h0);
        check("apply2_gnt",     32'(gnt),         32'h0);
        step();
        check("post_gnt", 32'(gnt),     32'h2);
        check("post_oe",  32'(obuf_oe), 32'h1);

        // Reset while driving.
        step();
        step();
        reset = 1'b1; stc_load = 1'b1; stc_code = 16'hFFFF;
        step();
        reset = 1'b0; stc_load = 1'b0; stc_code = 16'h0;
        check("mid_rst_gnt",     32'(gnt),         32'h0);
        check("mid_rst_oe",      32'(obuf_oe),     32'h0);
        check("mid_rst_devoe",   32'(obuf_devoe),  32'h0);
        check("mid_rst_stc",     32'(obuf_stc),    32'h0);
        check("mid_rst_pending", 32'(stc_pending), 32'h0);

        // Mixed traffic, checked by the model only.
        for (int k = 0; k < 300; k++) begin
            req      = 4'($urandom);
            req_data = 4'($urandom);
            stc_load = ($urandom_range(0, 7) == 0);
            stc_code = 16'($urandom);
            reset    = (k == 200);
            step();
        end
        reset = 1'b0; stc_load = 1'b0; req = 4'b0;
        step();
        step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
